blink_monitor: RTL and testbench
================================

// Module: blink_monitor
// PURPOSE
//   Receive-side counterpart to the board's LED blink generators. Samples an
//   asynchronous toggling input (a blink line), measures each half-period in clk
//   cycles and checks it against an expected value. Reports lock, fault and
//   status LEDs. Used on-board to check that a blink source runs at its intended rate.
// PARAMETERS
//   CNT_W       28        width of interval counter / half_period output
//   EXP_HALF    2**27     expected cycles between consecutive blink_in edges
//   TOL         1024      allowed |measured - EXP_HALF| for an in-tolerance interval
//   LOCK_CNT    4         consecutive in-tolerance intervals required to lock (>=1)
//   SYNC_STAGES 2         synchronizer flops on blink_in (>=2)
// PORTS
//   clk          in   1      clock
//   rst          in   1      synchronous, active-high reset
//   blink_in     in   1      asynchronous blink line under test
//   clear_fault  in   1      single-cycle pulse; leaves FAULT
//   half_period  out  CNT_W  last measured edge-to-edge interval (cycles)
//   period_valid out  1      1-cycle pulse when half_period updates
//   edge_count   out  8      detected edges, wraps 255->0
//   locked       out  1      state==LOCKED
//   fault        out  1      state==FAULT (sticky)
//   led          out  4      {fault, locked, state==ACQUIRE, synced blink level}
// BEHAVIOUR
//   Reset: sync chain, prev level, counter, good_cnt, half_period, edge_count = 0.
//     period_valid/locked/fault = 0. State = IDLE. Applies mid-operation too.
//     All outputs read 0 the cycle after rst is sampled high.
//   Sync: SYNC_STAGES flops, then prev flop. edge = sync_out ^ prev, in cycle E.
//     E is SYNC_STAGES cycles after the blink_in change reaches the first flop.
//   Interval: measured = cycles between consecutive edge cycles (E1-E0). Counter
//     saturates at 2^CNT_W-1; a saturated measurement reports 2^CNT_W-1.
//   Registered outputs: on edge in cycle E, at the clock ending E:
//     - edge_count += 1.
//     - If a prior edge exists, half_period <= measured and period_valid = 1 during E+1.
//     - State update happens at the same clock.
//   First edge after reset / IDLE entry has no prior edge: no period_valid.
//   in_tol = (measured >= EXP_HALF-TOL) && (measured <= EXP_HALF+TOL).
//     Saturated measurements are never in_tol. Use CNT_W+1-bit compare; no underflow.
//   timeout = counter reaches EXP_HALF+TOL+1 with no edge. Fires once per gap.
//   FSM:
//     IDLE:    edge -> ACQUIRE, good_cnt=0.
//     ACQUIRE: in_tol meas -> good_cnt+1; good_cnt+1==LOCK_CNT -> LOCKED.
//              out-of-tol meas or timeout -> good_cnt=0, stay.
//     LOCKED:  in_tol meas -> stay; out-of-tol meas or timeout -> FAULT.
//     FAULT:   sticky; measurement still updates half_period/edge_count.
//              clear_fault -> IDLE; counter and good_cnt cleared.
//   Simultaneous events:
//     - clear_fault with an edge in FAULT: clear wins; the edge counts only in
//       edge_count, and the next edge is treated as the first.
//     - clear_fault outside FAULT: ignored.
//     - rst beats everything.
// TESTING (CNT_W=8, EXP_HALF=16, TOL=2, LOCK_CNT=4, SYNC_STAGES=2)
//   1 toggle every 16 cycles -> period_valid pulses with half_period=16.
//     locked=1 the cycle after the 5th edge's E (4 good intervals); led[2]=1 before that.
//   2 intervals 16,18,14,19,16... -> 19 clears good_cnt; lock only after 4 further
//     in-tol intervals; 13 and 19 also reject; 14 and 18 accept.
//   3 locked, stop toggling -> fault=1, locked=0 when counter hits 19 (timeout).
//   4 locked, one interval of 10 -> fault=1 the cycle after that edge's E.
//     clear_fault with a simultaneous edge -> IDLE; no period_valid on the next edge.
//   5 ACQUIRE, no edge for 300 cycles then edge -> half_period=255, good_cnt=0.
//     Then 256 total edges -> edge_count wraps to 0.
//   6 rst asserted while LOCKED -> next cycle all outputs 0, state IDLE.
//     blink_in pulse shorter than 1 clk is either missed or counted as 2 edges, never X.

Source files
------------

// File: rtl/blink_monitor_if.sv
// Bundle of the blink line, fault clear and measurement/status outputs of blink_monitor.
// master drives the blink line and clear; slave is the monitor.
interface blink_monitor_if #(
  parameter int CNT_W = 28
);
  logic             blink_in;
  logic             clear_fault;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic [7:0]       edge_count;
  logic             locked;
  logic             fault;
  logic [3:0]       led;

  modport master (
    output blink_in, clear_fault,
    input  half_period, period_valid, edge_count, locked, fault, led
  );

  modport slave (
    input  blink_in, clear_fault,
    output half_period, period_valid, edge_count, locked, fault, led
  );
endinterface

// File: rtl/blink_monitor.sv
// Measures edge-to-edge intervals of an asynchronous blink line and tracks lock/fault.
// Outputs update one clock after the synchronized edge cycle; there is no backpressure.
module blink_monitor #(
  parameter int CNT_W       = 28,
  parameter int EXP_HALF    = 2**27,
  parameter int TOL         = 1024,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  blink_monitor_if.slave  bus
);

  localparam int GC_W = $clog2(LOCK_CNT + 1);
  localparam int LO_I = (EXP_HALF > TOL) ? EXP_HALF - TOL : 0;
  localparam int HI_I = EXP_HALF + TOL;
  localparam int TO_I = HI_I + 1;
  localparam logic [CNT_W:0]  LO_BOUND = LO_I[CNT_W:0];
  localparam logic [CNT_W:0]  HI_BOUND = HI_I[CNT_W:0];
  localparam logic [CNT_W:0]  TO_BOUND = TO_I[CNT_W:0];
  localparam logic [GC_W-1:0] LOCK_GC  = LOCK_CNT[GC_W-1:0];

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [GC_W-1:0]        good_q, good_d, good_inc;
  logic [CNT_W-1:0]       half_period_q;
  logic                   period_valid_q;
  logic [7:0]             edge_count_q;
  logic                   sync_lvl, edge_det, in_tol, timeout;
  logic                   meas_upd, cnt_clr;
  logic [CNT_W:0]         cnt_ext;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_lvl ^ prev_q;
  assign cnt_ext  = {1'b0, cnt_q};
  assign good_inc = good_q + 1'b1;

  // A saturated counter means the true interval is unknown, so it never qualifies.
  assign in_tol  = (cnt_q != '1) && (cnt_ext >= LO_BOUND) && (cnt_ext <= HI_BOUND);
  assign timeout = (cnt_ext == TO_BOUND);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.blink_in};
      prev_q <= sync_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    meas_upd = 1'b0;
    cnt_clr  = 1'b0;
    if ((state_q == FAULT) && bus.clear_fault) begin
      // Clear beats a coincident edge: that edge only bumps edge_count.
      state_d = IDLE;
      good_d  = '0;
      cnt_clr = 1'b1;
    end else if (edge_det) begin
      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
        ACQUIRE: begin
          meas_upd = 1'b1;
          if (!in_tol) begin
            good_d = '0;
          end else if (good_inc == LOCK_GC) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_inc;
          end
        end
        LOCKED: begin
          meas_upd = 1'b1;
          if (!in_tol) state_d = FAULT;
        end
        FAULT: meas_upd = 1'b1;
        default: ;
      endcase
    end else if (timeout) begin
      unique case (state_q)
        ACQUIRE: good_d  = '0;
        LOCKED:  state_d = FAULT;
        default: ;
      endcase
    end
  end

  // Counter holds cycles since the last edge; it passes the timeout value once per gap.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_q <= '0;
    end else if (edge_det) begin
      cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if ((state_q != IDLE) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      edge_count_q   <= '0;
    end else begin
      period_valid_q <= meas_upd;
      if (meas_upd) half_period_q <= cnt_q;
      if (edge_det) edge_count_q <= edge_count_q + 1'b1;
    end
  end

  assign bus.half_period  = half_period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.edge_count   = edge_count_q;
  assign bus.locked       = (state_q == LOCKED);
  assign bus.fault        = (state_q == FAULT);
  assign bus.led          = {state_q == FAULT, state_q == LOCKED, state_q == ACQUIRE, sync_lvl};

endmodule

// File: tb/tb_blink_monitor.sv
// Directed and randomized blink patterns against a cycle-indexed reference of the monitor rules.
module tb_blink_monitor;
  localparam int EXP   = 16;
  localparam int TOL   = 2;
  localparam int LOCKN = 4;
  localparam int SAT   = 255;
  localparam int TO    = EXP + TOL + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blink_monitor_if #(.CNT_W(8)) bus ();

  blink_monitor #(
    .CNT_W(8), .EXP_HALF(EXP), .TOL(TOL), .LOCK_CNT(LOCKN), .SYNC_STAGES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int win = 0;
  int pend[$];
  // Reference state: mode 0 idle, 1 acquiring, 2 locked, 3 fault.
  int m_mode, m_good, m_last, m_hp, m_pv, m_ec;
  bit m_lvl;
  logic lvl_drv;

  task automatic chk(string tag, logic [31:0] obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d window=%0d", tag, obs, exp, win);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_last = 0;
    m_hp = 0; m_pv = 0; m_ec = 0; m_lvl = 1'b0;
    pend.delete();
  endtask

  task automatic check_outputs();
    bit e_now;
    e_now = (pend.size() > 0) && (pend[0] == win);
    chk("half_period", 32'(bus.half_period), m_hp);
    chk("period_valid", 32'(bus.period_valid), m_pv);
    chk("edge_count", 32'(bus.edge_count), m_ec);
    chk("locked", 32'(bus.locked), int'(m_mode == 2));
    chk("fault", 32'(bus.fault), int'(m_mode == 3));
    chk("led", 32'(bus.led), int'({m_mode == 3, m_mode == 2, m_mode == 1, m_lvl ^ e_now}));
  endtask

  // Applies the monitor rules to window 'win' given edge/clear/reset in that window.
  task automatic step(bit r, bit clr);
    bit e, intol;
    int meas;
    e = (pend.size() > 0) && (pend[0] == win);
    if (e) void'(pend.pop_front());
    if (r) begin
      model_reset();
      return;
    end
    m_pv  = 0;
    meas  = win - m_last;
    if (meas > SAT) meas = SAT;
    intol = (meas != SAT) && (meas >= EXP - TOL) && (meas <= EXP + TOL);
    if (e) begin
      m_ec  = (m_ec + 1) % 256;
      m_lvl = ~m_lvl;
      if (m_mode == 3 && clr) begin
        m_mode = 0; m_good = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_good = 0;
      end else begin
        m_hp = meas; m_pv = 1;
        if (m_mode == 1) begin
          if (intol) begin
            m_good++;
            if (m_good == LOCKN) m_mode = 2;
          end else begin
            m_good = 0;
          end
        end else if (m_mode == 2 && !intol) begin
          m_mode = 3;
        end
      end
      m_last = win;
    end else if (m_mode == 3 && clr) begin
      m_mode = 0; m_good = 0;
    end else if ((m_mode == 1 || m_mode == 2) && (win - m_last == TO)) begin
      if (m_mode == 2) m_mode = 3;
      else m_good = 0;
    end
  endtask

  task automatic tick(bit tog, bit clr, bit r = 1'b0);
    @(negedge clk);
    check_outputs();
    rst = r;
    bus.clear_fault = clr;
    if (tog) begin
      lvl_drv = ~lvl_drv;
      bus.blink_in = lvl_drv;
      pend.push_back(win + 2);
    end
    if (r) begin
      lvl_drv = 1'b0;
      bus.blink_in = 1'b0;
    end
    step(r, clr);
    @(posedge clk);
    win++;
  endtask

  task automatic gap(int g);
    for (int i = 1; i < g; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic gap_rand(int g);
    for (int i = 1; i < g; i++) tick(1'b0, $urandom_range(0, 31) == 0);
    tick(1'b1, $urandom_range(0, 31) == 0);
  endtask

  int t2_seq[12] = '{16, 18, 14, 19, 16, 16, 13, 16, 16, 16, 16, 16};

  initial begin
    rst = 1'b1;
    bus.blink_in = 1'b0;
    bus.clear_fault = 1'b0;
    lvl_drv = 1'b0;
    model_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0);

    // Steady 16-cycle toggling until lock, then silence until timeout.
    repeat (6) gap(16);
    repeat (25) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    // Tolerance boundaries during acquisition.
    foreach (t2_seq[i]) gap(t2_seq[i]);

    // Short interval while locked, then clear coincident with an edge.
    repeat (5) gap(16);
    gap(10);
    repeat (15) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (3) gap(16);

    // Randomized intervals mostly near the target, with sporadic clears.
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) gap_rand($urandom_range(1, 30));
      else gap_rand($urandom_range(EXP - TOL - 1, EXP + TOL + 1));
    end

    // Long gap during acquisition saturates the measurement; then wrap edge_count.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0);
    gap(16);
    gap(16);
    repeat (300) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (260) gap(2);
    repeat (4) tick(1'b0, 1'b0);

    // Reset while locked, then a sub-cycle pulse that no clock edge sees.
    repeat (6) gap(16);
    repeat (4) tick(1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0);
    @(negedge clk);
    #1 bus.blink_in = 1'b1;
    #1 bus.blink_in = 1'b0;
    @(posedge clk);
    step(1'b0, 1'b0);
    win++;
    repeat (6) tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
